gpio_in_mux_flt: RTL and testbench
==================================

Name: gpio_in_mux_flt

Overview:
Parametrised next-generation GPIO input mux.
- Routes any of NUM_PAD pad inputs to each of NUM_FN peripheral function inputs through a per-function pad select.
- Adds pad synchronisation, a per-function programmable glitch filter and edge-pulse outputs.
- Sits between the pad ring and the peripheral input ports (SPI, I2C, JTAG, test). Select and enable fields are driven from the pinmux register bank.

Parameters:
NUM_PAD, 16, number of pad inputs
NUM_FN, 17, number of function outputs
SEL_W, 5, width of each function's pad-select field; must satisfy 2^SEL_W >= NUM_PAD
FLT_W, 4, width of filter length and counters
SYNC_STAGES, 2, synchroniser depth (>= 2)
FN_DFLT, {NUM_FN{1'b0}}, per-function default value; used when the function is disabled or its select is out of range, and as the output reset value

Ports:
clk  in  1  block clock
rst  in  1  asynchronous active-high reset
pad_in  in  NUM_PAD  raw pad inputs, asynchronous to clk
fn_en  in  NUM_FN  per-function enable (quasi-static register)
fn_pad_sel  in  NUM_FN*SEL_W  per-function pad index; field f is [f*SEL_W +: SEL_W]
flt_len  in  FLT_W  glitch filter length, shared by all functions; 0 = no filtering
fn_out  out  NUM_FN  filtered function inputs to the peripherals
fn_rise  out  NUM_FN  one-cycle pulse when fn_out[f] goes 0->1
fn_fall  out  NUM_FN  one-cycle pulse when fn_out[f] goes 1->0

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all synchroniser flops = 0
  - fn_out = FN_DFLT
  - filter counters = 0
  - fn_rise = fn_fall = 0
  - config shadow registers = 0
- Synchroniser: pad_s = pad_in delayed through SYNC_STAGES flops per pad. No filtering is applied before the mux.
- Mux (combinational), per function f: raw[f] = pad_s[fn_pad_sel_f] if fn_en[f]=1 and fn_pad_sel_f < NUM_PAD, else FN_DFLT[f].
- Several functions may select the same pad. A pad with no function selecting it is ignored.
- Glitch filter, per function, evaluated each cycle in this priority order:
  - config change: fn_en[f] or fn_pad_sel_f differs from its registered shadow -> cnt := 0, fn_out held, shadow updated.
  - raw[f] == fn_out[f] -> cnt := 0.
  - cnt >= flt_len -> fn_out[f] := raw[f], cnt := 0.
  - otherwise -> cnt := cnt + 1.
- Result: fn_out changes only after raw differs from it for flt_len+1 consecutive cycles. With flt_len=0, fn_out follows raw with 1-cycle delay.
- flt_len changed mid-count: the comparison uses the new value immediately. Because the test is >=, a counter already past the new length updates fn_out on the next cycle.
- Counter saturation: cnt never exceeds 2^FLT_W-1, because the >= test fires before wrap.
- Latency: pad edge to fn_out = SYNC_STAGES + flt_len + 1 cycles.
- Edge pulses: fn_rise/fn_fall are registered and asserted in the same cycle fn_out takes its new value, for exactly one cycle.
  - Back-to-back toggles with flt_len=0 produce alternating pulses every cycle.
  - No pulse is produced on the first cycle after reset.
- Reconfiguration does not force fn_out to the default. A disabled function drifts to FN_DFLT[f] through the filter (flt_len+1 cycles), so peripherals never see a single-cycle glitch.
- Reset mid-operation: all state returns to reset values immediately. No pulses are emitted during or on release of reset.

Decomposition:
- Package gpio_mux_pkg holds:
  - PAD_IDX_W = $clog2(NUM_PAD)
  - function index localparams (FN_SPI_AP_CLK, FN_I2C0_CLK, ...)
  - default FN_DFLT vector for the chip
- One sub-module gpio_in_flt: single-channel filter counter, output flop, edge pulse and config-shadow compare. Instantiated NUM_FN times in a generate loop.
- Synchroniser and mux stay in the top.

Test Plan:
1. Reset released, fn_en=0, FN_DFLT[3]=1 -> fn_out[3]=1 and no fn_rise/fn_fall pulses for 100 cycles.
2. fn_en[0]=1, fn_pad_sel_0=5, flt_len=0; pad_in[5] 0->1 at cycle 10 -> fn_out[0]=1 at cycle 13 with fn_rise[0] high for exactly cycle 13.
3. flt_len=3; pad_in[5] high for 3 cycles then low -> fn_out unchanged, no pulse. Pad held high for 4+ cycles -> fn_out rises 2+3+1=6 cycles after the pad edge.
4. fn_pad_sel_0 switched 5->20 (out of range, NUM_PAD=16) while pad 5 = 1, FN_DFLT[0]=0, flt_len=2 -> fn_out[0] stays 1 for 3 cycles after the change is seen, then falls with one fn_fall pulse.
5. Functions 1 and 2 both select pad 7; toggle pad 7 -> both outputs and both edge pulses match cycle-for-cycle.
6. Assert rst while cnt=2 of flt_len=5 and fn_out=1 -> fn_out = FN_DFLT immediately and cnt=0. After release the filter restarts from 0, taking the full 6 cycles.

Source files
------------

// File: rtl/gpio_mux_pkg.sv
// rtl/gpio_mux_pkg.sv - chip-level constants for the GPIO input mux
// Purpose: default geometry of the input mux, function index map and the
//          chip default value driven to each peripheral input.
// Ports:   none (package).
package gpio_mux_pkg;

  localparam int NUM_PAD     = 16;
  localparam int NUM_FN      = 17;
  localparam int SEL_W       = 5;
  localparam int FLT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int PAD_IDX_W   = $clog2(NUM_PAD);

  // Function index map (bit position in fn_en / fn_out / fn_rise / fn_fall).
  localparam int FN_SPI_AP_CLK   = 0;
  localparam int FN_SPI_AP_CS_N  = 1;
  localparam int FN_SPI_AP_MOSI  = 2;
  localparam int FN_I2C0_CLK     = 3;
  localparam int FN_I2C0_DAT     = 4;
  localparam int FN_I2C1_CLK     = 5;
  localparam int FN_I2C1_DAT     = 6;
  localparam int FN_JTAG_TCK     = 7;
  localparam int FN_JTAG_TMS     = 8;
  localparam int FN_JTAG_TDI     = 9;
  localparam int FN_JTAG_TRST_N  = 10;
  localparam int FN_TEST_MODE    = 11;
  localparam int FN_TEST_SCAN_EN = 12;
  localparam int FN_TEST_SCAN_I0 = 13;
  localparam int FN_TEST_SCAN_I1 = 14;
  localparam int FN_TEST_SCAN_I2 = 15;
  localparam int FN_TEST_SCAN_I3 = 16;

  // I2C lines idle high (open-drain bus), JTAG TMS idles high so the TAP
  // stays in reset; everything else idles low.
  localparam logic [NUM_FN-1:0] FN_DFLT_CHIP =
      (NUM_FN'(1) << FN_I2C0_CLK) | (NUM_FN'(1) << FN_I2C0_DAT) |
      (NUM_FN'(1) << FN_I2C1_CLK) | (NUM_FN'(1) << FN_I2C1_DAT) |
      (NUM_FN'(1) << FN_JTAG_TMS);

endpackage

// File: rtl/gpio_in_flt.sv
// rtl/gpio_in_flt.sv - single-channel glitch filter with edge pulses
// Purpose: holds out_o until raw_i has differed from it for flt_len_i+1
//          consecutive cycles; restarts the count whenever the channel's
//          enable/select configuration changes.
// Ports:   clk, rst       - clock, async active-high reset
//          raw_i          - muxed, synchronised input for this channel
//          en_i, sel_i    - channel configuration (shadowed to detect change)
//          flt_len_i      - filter length, 0 = one-cycle follow
//          out_o          - filtered value
//          rise_o, fall_o - one-cycle pulses aligned with out_o changes
module gpio_in_flt
  import gpio_mux_pkg::*;
#(
  parameter int   FLT_W = gpio_mux_pkg::FLT_W,
  parameter int   SEL_W = gpio_mux_pkg::SEL_W,
  parameter logic DFLT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_i,
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic [FLT_W-1:0] flt_len_i,
  output logic             out_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic             en_sh_q;
  logic [SEL_W-1:0] sel_sh_q;
  logic [FLT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             cfg_chg;

  assign cfg_chg = (en_i != en_sh_q) || (sel_i != sel_sh_q);

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (cfg_chg) begin
      // Hold the output across a reconfiguration; the new source must then
      // win the full filter length before it is passed on.
      cnt_d = '0;
    end else if (raw_i == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= flt_len_i) begin
      // >= so a length reduced mid-count takes effect immediately and the
      // counter can never wrap.
      out_d = raw_i;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + FLT_W'(1);
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sh_q  <= 1'b0;
      sel_sh_q <= '0;
      cnt_q    <= '0;
      out_q    <= DFLT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      en_sh_q  <= en_i;
      sel_sh_q <= sel_i;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_mux_flt.sv
// rtl/gpio_in_mux_flt.sv - GPIO input mux with sync, glitch filter and edges
// Purpose: synchronises the pad ring inputs, routes any pad to each peripheral
//          function input via a per-function select, and filters each result.
// Ports:   clk, rst    - clock, async active-high reset
//          pad_in      - raw asynchronous pad inputs
//          fn_en       - per-function enable
//          fn_pad_sel  - per-function pad index, field f at [f*SEL_W +: SEL_W]
//          flt_len     - shared glitch filter length
//          fn_out      - filtered function inputs
//          fn_rise     - one-cycle pulse on fn_out 0->1
//          fn_fall     - one-cycle pulse on fn_out 1->0
module gpio_in_mux_flt
  import gpio_mux_pkg::*;
#(
  parameter int                NUM_PAD     = gpio_mux_pkg::NUM_PAD,
  parameter int                NUM_FN      = gpio_mux_pkg::NUM_FN,
  parameter int                SEL_W       = gpio_mux_pkg::SEL_W,
  parameter int                FLT_W       = gpio_mux_pkg::FLT_W,
  parameter int                SYNC_STAGES = gpio_mux_pkg::SYNC_STAGES,
  parameter logic [NUM_FN-1:0] FN_DFLT     = {NUM_FN{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PAD-1:0]      pad_in,
  input  logic [NUM_FN-1:0]       fn_en,
  input  logic [NUM_FN*SEL_W-1:0] fn_pad_sel,
  input  logic [FLT_W-1:0]        flt_len,
  output logic [NUM_FN-1:0]       fn_out,
  output logic [NUM_FN-1:0]       fn_rise,
  output logic [NUM_FN-1:0]       fn_fall
);

  localparam int               IDX_W     = $clog2(NUM_PAD);
  // One extra bit so NUM_PAD == 2**SEL_W does not truncate to zero.
  localparam logic [SEL_W:0]   PAD_LIMIT = (SEL_W+1)'(NUM_PAD);

  logic [SYNC_STAGES-1:0][NUM_PAD-1:0] sync_q;
  logic [NUM_PAD-1:0]                  pad_s;
  logic [NUM_FN-1:0]                   raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign pad_s = sync_q[SYNC_STAGES-1];

  for (genvar f = 0; f < NUM_FN; f++) begin : g_fn
    logic [SEL_W-1:0] sel;
    logic             sel_ok;

    assign sel    = fn_pad_sel[f*SEL_W +: SEL_W];
    assign sel_ok = ({1'b0, sel} < PAD_LIMIT);
    assign raw[f] = (fn_en[f] && sel_ok) ? pad_s[sel[IDX_W-1:0]] : FN_DFLT[f];

    gpio_in_flt #(
      .FLT_W (FLT_W),
      .SEL_W (SEL_W),
      .DFLT  (FN_DFLT[f])
    ) u_flt (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (raw[f]),
      .en_i      (fn_en[f]),
      .sel_i     (sel),
      .flt_len_i (flt_len),
      .out_o     (fn_out[f]),
      .rise_o    (fn_rise[f]),
      .fall_o    (fn_fall[f])
    );
  end

endmodule

// File: tb/tb_gpio_in_mux_flt.sv
// tb/tb_gpio_in_mux_flt.sv - self-checking bench for gpio_in_mux_flt
module tb_gpio_in_mux_flt;
  import gpio_mux_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_PAD-1:0]      pad_in;
  logic [NUM_FN-1:0]       fn_en;
  logic [NUM_FN*SEL_W-1:0] fn_pad_sel;
  logic [FLT_W-1:0]        flt_len;
  logic [NUM_FN-1:0]       fn_out;
  logic [NUM_FN-1:0]       fn_rise;
  logic [NUM_FN-1:0]       fn_fall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_in_mux_flt #(
    .NUM_PAD     (NUM_PAD),
    .NUM_FN      (NUM_FN),
    .SEL_W       (SEL_W),
    .FLT_W       (FLT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .FN_DFLT     (FN_DFLT_CHIP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_in     (pad_in),
    .fn_en      (fn_en),
    .fn_pad_sel (fn_pad_sel),
    .flt_len    (flt_len),
    .fn_out     (fn_out),
    .fn_rise    (fn_rise),
    .fn_fall    (fn_fall)
  );

  typedef struct {
    int          fn;
    logic        en;
    logic [4:0]  sel;
    logic [15:0] pad;
    logic        exp_out;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int f, input logic [SEL_W-1:0] s);
    fn_pad_sel[f*SEL_W +: SEL_W] = s;
  endtask

  initial begin
    int         bad;
    logic       expv;
    logic       prev;
    logic [11:0] pat;

    vecs[0] = '{0,  1'b1, 5'd5,  16'h0020, 1'b1};
    vecs[1] = '{0,  1'b1, 5'd5,  16'hFFDF, 1'b0};
    vecs[2] = '{3,  1'b0, 5'd0,  16'hFFFF, 1'b1};
    vecs[3] = '{3,  1'b1, 5'd2,  16'h0000, 1'b0};
    vecs[4] = '{3,  1'b1, 5'd31, 16'h0000, 1'b1};
    vecs[5] = '{0,  1'b1, 5'd16, 16'hFFFF, 1'b0};
    vecs[6] = '{16, 1'b1, 5'd15, 16'h8000, 1'b1};
    vecs[7] = '{16, 1'b1, 5'd15, 16'h7FFF, 1'b0};
    vecs[8] = '{9,  1'b1, 5'd0,  16'h0001, 1'b1};
    vecs[9] = '{4,  1'b0, 5'd2,  16'h0000, 1'b1};

    rst        = 1'b1;
    pad_in     = '0;
    fn_en      = '0;
    fn_pad_sel = '0;
    flt_len    = '0;
    step(2);
    chk("reset_out",  fn_out,  FN_DFLT_CHIP);
    chk("reset_rise", fn_rise, 0);
    chk("reset_fall", fn_fall, 0);

    // Idle after reset: defaults hold, no pulses.
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (fn_out[3] !== 1'b1 || fn_rise !== '0 || fn_fall !== '0) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    chk("idle_out", fn_out, FN_DFLT_CHIP);

    // Routing table, flt_len = 0.
    for (int i = 0; i < 10; i++) begin
      fn_en[vecs[i].fn] = vecs[i].en;
      set_sel(vecs[i].fn, vecs[i].sel);
      pad_in = vecs[i].pad;
      step(6);
      chk($sformatf("vec%0d_fn%0d", i, vecs[i].fn), fn_out[vecs[i].fn], vecs[i].exp_out);
    end
    fn_en      = '0;
    fn_pad_sel = '0;
    pad_in     = '0;
    step(6);
    chk("table_restore", fn_out, FN_DFLT_CHIP);

    // Pad 5 -> fn 0, flt_len 0: latency 3.
    fn_en[0] = 1'b1;
    set_sel(0, 5'd5);
    step(8);
    chk("t2_pre", fn_out[0], 0);
    pad_in[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("t2_out_k%0d", k),  fn_out[0],  (k >= 3));
      chk($sformatf("t2_rise_k%0d", k), fn_rise[0], (k == 3));
    end

    // flt_len 3: 3-cycle glitch rejected, 4+ cycles pass after 6.
    flt_len   = 4'd3;
    pad_in[5] = 1'b0;
    step(8);
    chk("t3_pre", fn_out[0], 0);
    pad_in[5] = 1'b1;
    step(3);
    pad_in[5] = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (fn_out[0] !== 1'b0 || fn_rise[0] !== 1'b0) bad++;
    end
    chk("t3_glitch_rejected", bad, 0);
    pad_in[5] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("t3_out_k%0d", k),  fn_out[0],  (k >= 6));
      chk($sformatf("t3_rise_k%0d", k), fn_rise[0], (k == 6));
    end

    // Select moved out of range: drift to default through the filter.
    flt_len = 4'd2;
    set_sel(0, 5'd20);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("t4_out_k%0d", k),  fn_out[0],  (k < 4));
      chk($sformatf("t4_fall_k%0d", k), fn_fall[0], (k == 4));
    end

    // Two functions sharing pad 7, back-to-back toggles.
    flt_len   = 4'd0;
    fn_en[1]  = 1'b1;
    fn_en[2]  = 1'b1;
    set_sel(1, 5'd7);
    set_sel(2, 5'd7);
    pad_in[7] = 1'b0;
    step(6);
    chk("t5_pre", fn_out[2:1], 2'b00);
    pat  = 12'b0110_1011_0101;
    prev = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pad_in[7] = (k < 12) ? pat[k] : 1'b0;
      step(1);
      expv = (k >= 2 && k - 2 < 12) ? pat[k-2] : 1'b0;
      chk($sformatf("t5_out_k%0d", k),  fn_rise[2:1] === 2'bxx ? 2'b11 : fn_out[2:1], {expv, expv});
      chk($sformatf("t5_rise_k%0d", k), fn_rise[2:1], {2{expv & ~prev}});
      chk($sformatf("t5_fall_k%0d", k), fn_fall[2:1], {2{~expv & prev}});
      prev = expv;
    end

    // Reset mid-count, then a full-length restart.
    flt_len   = 4'd5;
    set_sel(0, 5'd5);
    pad_in[5] = 1'b1;
    step(10);
    chk("t6_pre", fn_out[0], 1);
    pad_in[5] = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    chk("t6_rst_out",  fn_out,  FN_DFLT_CHIP);
    chk("t6_rst_rise", fn_rise, 0);
    chk("t6_rst_fall", fn_fall, 0);
    step(2);
    chk("t6_rst_hold", {fn_rise, fn_fall}, 0);
    rst       = 1'b0;
    pad_in[5] = 1'b1;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk($sformatf("t6_out_k%0d", k),  fn_out[0],  (k >= 8));
      chk($sformatf("t6_rise_k%0d", k), fn_rise[0], (k == 8));
      if (fn_fall !== '0 || fn_rise[NUM_FN-1:1] !== '0) bad++;
    end
    chk("t6_no_stray_pulse", bad, 0);

    // flt_len shrunk below a running count: update on the next cycle.
    flt_len   = 4'd8;
    pad_in[5] = 1'b0;
    step(7);
    chk("t7_hold_out",  fn_out[0],  1);
    chk("t7_hold_fall", fn_fall[0], 0);
    flt_len = 4'd2;
    step(1);
    chk("t7_out",  fn_out[0],  0);
    chk("t7_fall", fn_fall[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
